dcache_ctrl: RTL and testbench

//  Miss-handling controller for the direct-mapped data cache, between the memory stage and the four-bank memory.

---
 rtl/dcache_ctrl_pkg.sv | 42 ++++
 rtl/dcache_ctrl_fill_pipe.sv | 45 ++++
 rtl/dcache_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types and geometry for the data-cache miss controller.
package dcache_ctrl_pkg;

    localparam int TAG_W  = 5;
    localparam int IDX_W  = 8;
    localparam int OFF_W  = 3;
    localparam int WORDS  = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    // Declaration order matters: WB0..RD3 advance by +1 in the controller.
    typedef enum logic [3:0] {
        IDLE, WB0, WB1, WB2, WB3, RD0, RD1, RD2, RD3, WAIT, FINAL
    } stateT;

    // Miss request captured on the miss-detect cycle and replayed in FINAL.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [1:0]        word;
        logic [DATA_W-1:0] data;
        logic              wr;
    } missReqT;

    // Word address of one word of a line; plain concatenation, wraps at 16 bits.
    function automatic logic [ADDR_W-1:0] lineAddr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx,
                                                   input logic [1:0]       word);
        return {tag, idx, word, 1'b0};
    endfunction

    // Which line word a WB/RD state works on.
    function automatic logic [1:0] stateWord(input stateT s);
        case (s)
            WB1, RD1: return 2'd1;
            WB2, RD2: return 2'd2;
            WB3, RD3: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dcache_ctrl_fill_pipe.sv
// Tracks outstanding memory reads: a MEM_LAT-deep valid/word shift register
// whose output stage lines up with m_data_out.
module dcache_ctrl_fill_pipe #(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [1:0] pushWord,
    output logic       outValid,
    output logic [1:0] outWord,
    output logic       emptyNext
);

    logic [MEM_LAT:1]      vldPipe;
    logic [MEM_LAT:1][1:0] wordPipe;
    logic                  inner;

    // Shift issued reads toward the output; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vldPipe  <= '0;
            wordPipe <= '0;
        end else begin
            vldPipe[1]  <= push;
            wordPipe[1] <= pushWord;
            for (int i = 2; i <= MEM_LAT; i++) begin
                vldPipe[i]  <= vldPipe[i-1];
                wordPipe[i] <= wordPipe[i-1];
            end
        end
    end

    // Anything still queued behind the output stage.
    always_comb begin
        inner = 1'b0;
        for (int i = 1; i < MEM_LAT; i++) inner = inner | vldPipe[i];
    end

    assign outValid  = vldPipe[MEM_LAT];
    assign outWord   = wordPipe[MEM_LAT];
    // Empty once the word at the output is consumed this cycle.
    assign emptyNext = ~push & ~inner;

endmodule

// File: rtl/dcache_ctrl.sv
// Miss-handling controller for the direct-mapped data cache: hit compare,
// dirty-victim write-back and 4-word line fill against a fixed-latency memory.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Rd,
    input  logic              Wr,
    output logic [DATA_W-1:0] DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              Err,
    output logic              c_enable,
    output logic              c_comp,
    output logic              c_write,
    output logic              c_valid_in,
    output logic [IDX_W-1:0]  c_index,
    output logic [OFF_W-1:0]  c_offset,
    output logic [TAG_W-1:0]  c_tag_in,
    output logic [DATA_W-1:0] c_data_in,
    input  logic              c_hit,
    input  logic              c_valid,
    input  logic              c_dirty,
    input  logic [TAG_W-1:0]  c_tag_out,
    input  logic [DATA_W-1:0] c_data_out,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data_in,
    output logic              m_wr,
    output logic              m_rd,
    input  logic [DATA_W-1:0] m_data_out
);

    stateT   state, nextState;
    missReqT reqQ;
    logic    latch;
    logic    push;
    logic [1:0] word;
    logic    fillValid;
    logic [1:0] fillWord;
    logic    pipeEmptyNext;
    logic    reqOk, reqErr;

    assign reqOk  = (Rd ^ Wr) & ~Addr[0];
    assign reqErr = (Rd | Wr) & (Addr[0] | (Rd & Wr));
    assign word   = stateWord(state);

    dcache_ctrl_fill_pipe #(.MEM_LAT(MEM_LAT)) uFillPipe (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pushWord (word),
        .outValid (fillValid),
        .outWord  (fillWord),
        .emptyNext(pipeEmptyNext)
    );

    // State register and capture of the missing request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            reqQ  <= '0;
        end else begin
            state <= nextState;
            if (latch)
                reqQ <= '{tag: Addr[15:11], idx: Addr[10:3], word: Addr[2:1],
                          data: DataIn, wr: Wr};
        end
    end

    // Next-state and all outputs; reset forces every output low.
    always_comb begin
        nextState  = state;
        latch      = 1'b0;
        push       = 1'b0;
        DataOut    = '0;
        Done       = 1'b0;
        Stall      = 1'b0;
        CacheHit   = 1'b0;
        Err        = 1'b0;
        c_enable   = 1'b0;
        c_comp     = 1'b0;
        c_write    = 1'b0;
        c_valid_in = 1'b0;
        c_index    = '0;
        c_offset   = '0;
        c_tag_in   = '0;
        c_data_in  = '0;
        m_addr     = '0;
        m_data_in  = '0;
        m_wr       = 1'b0;
        m_rd       = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (reqErr) begin
                        Err = 1'b1;
                    end else if (reqOk) begin
                        c_enable  = 1'b1;
                        c_comp    = 1'b1;
                        c_write   = Wr;
                        c_index   = Addr[10:3];
                        c_offset  = Addr[2:0];
                        c_tag_in  = Addr[15:11];
                        c_data_in = DataIn;
                        if (c_hit & c_valid) begin
                            Done     = 1'b1;
                            CacheHit = 1'b1;
                            DataOut  = c_data_out;
                        end else begin
                            Stall     = 1'b1;
                            latch     = 1'b1;
                            nextState = (c_valid & c_dirty) ? WB0 : RD0;
                        end
                    end
                end
                WB0, WB1, WB2, WB3: begin
                    // Victim word read straight out of the array onto the memory bus.
                    Stall     = 1'b1;
                    c_enable  = 1'b1;
                    c_index   = reqQ.idx;
                    c_offset  = {word, 1'b0};
                    m_wr      = 1'b1;
                    m_addr    = lineAddr(c_tag_out, reqQ.idx, word);
                    m_data_in = c_data_out;
                    nextState = stateT'(state + 4'd1);
                end
                RD0, RD1, RD2, RD3: begin
                    Stall     = 1'b1;
                    m_rd      = 1'b1;
                    m_addr    = lineAddr(reqQ.tag, reqQ.idx, word);
                    push      = 1'b1;
                    nextState = stateT'(state + 4'd1);
                end
                WAIT: begin
                    Stall = 1'b1;
                    if (pipeEmptyNext) nextState = FINAL;
                end
                FINAL: begin
                    // Replay the original access now that the line is resident.
                    c_enable  = 1'b1;
                    c_comp    = 1'b1;
                    c_write   = reqQ.wr;
                    c_index   = reqQ.idx;
                    c_offset  = {reqQ.word, 1'b0};
                    c_tag_in  = reqQ.tag;
                    c_data_in = reqQ.data;
                    Done      = 1'b1;
                    DataOut   = c_data_out;
                    nextState = IDLE;
                end
                default: nextState = IDLE;
            endcase
            // Returning memory data owns the array port; the line only turns
            // valid with its last word so a cut-short fill leaves it invalid.
            if (fillValid) begin
                c_enable   = 1'b1;
                c_comp     = 1'b0;
                c_write    = 1'b1;
                c_index    = reqQ.idx;
                c_offset   = {fillWord, 1'b0};
                c_tag_in   = reqQ.tag;
                c_data_in  = m_data_out;
                c_valid_in = (fillWord == 2'd3);
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with behavioural cache-array and memory models.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn;
    logic        Rd, Wr;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit, Err;
    logic        c_enable, c_comp, c_write, c_valid_in;
    logic [7:0]  c_index;
    logic [2:0]  c_offset;
    logic [4:0]  c_tag_in;
    logic [15:0] c_data_in;
    logic        c_hit, c_valid, c_dirty;
    logic [4:0]  c_tag_out;
    logic [15:0] c_data_out;
    logic [15:0] m_addr, m_data_in, m_data_out;
    logic        m_wr, m_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_ctrl #(.MEM_LAT(2)) dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .Err(Err),
        .c_enable(c_enable), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
        .c_index(c_index), .c_offset(c_offset), .c_tag_in(c_tag_in), .c_data_in(c_data_in),
        .c_hit(c_hit), .c_valid(c_valid), .c_dirty(c_dirty), .c_tag_out(c_tag_out),
        .c_data_out(c_data_out), .m_addr(m_addr), .m_data_in(m_data_in),
        .m_wr(m_wr), .m_rd(m_rd), .m_data_out(m_data_out)
    );

    logic [89:0] allOut;
    assign allOut = {DataOut, Done, Stall, CacheHit, Err, c_enable, c_comp, c_write,
                     c_valid_in, c_index, c_offset, c_tag_in, c_data_in, m_addr,
                     m_data_in, m_wr, m_rd};

    // ---------------- cache array model ----------------
    logic [4:0]  tagA   [256];
    logic        validA [256];
    logic        dirtyA [256];
    logic [15:0] dataA  [256][4];
    logic        tbInit = 1'b0;
    logic        preEn = 1'b0, preDirty = 1'b0;
    logic [7:0]  preIdx = '0;
    logic [4:0]  preTag = '0;
    logic [15:0] preBase = '0;

    assign c_hit      = (tagA[c_index] == c_tag_in);
    assign c_valid    = validA[c_index];
    assign c_dirty    = dirtyA[c_index];
    assign c_tag_out  = tagA[c_index];
    assign c_data_out = dataA[c_index][c_offset[2:1]];

    always @(posedge clk) begin
        if (tbInit) begin
            for (int i = 0; i < 256; i++) begin
                tagA[i] <= '0; validA[i] <= 1'b0; dirtyA[i] <= 1'b0;
                for (int k = 0; k < 4; k++) dataA[i][k] <= '0;
            end
        end else if (preEn) begin
            tagA[preIdx] <= preTag; validA[preIdx] <= 1'b1; dirtyA[preIdx] <= preDirty;
            for (int k = 0; k < 4; k++) dataA[preIdx][k] <= preBase + 16'(k);
        end else if (c_enable & c_write) begin
            if (c_comp) begin
                if (c_hit & c_valid) begin
                    dataA[c_index][c_offset[2:1]] <= c_data_in;
                    dirtyA[c_index] <= 1'b1;
                end
            end else begin
                dataA[c_index][c_offset[2:1]] <= c_data_in;
                tagA[c_index]   <= c_tag_in;
                validA[c_index] <= c_valid_in;
                dirtyA[c_index] <= 1'b0;
            end
        end
    end

    // ---------------- memory model, 2-cycle read latency ----------------
    logic [15:0] memA [32768];
    logic        pokeEn = 1'b0;
    logic [15:0] pokeAddr = '0, pokeData = '0;
    logic [15:0] rdQ1, rdQ2;

    always @(posedge clk) begin
        if (pokeEn) memA[pokeAddr[15:1]] <= pokeData;
        else if (m_wr) memA[m_addr[15:1]] <= m_data_in;
        rdQ1 <= memA[m_addr[15:1]];
        rdQ2 <= rdQ1;
    end
    assign m_data_out = rdQ2;

    // ---------------- stimulus helpers ----------------
    int          doneCyc;
    logic [15:0] doneData;
    logic        doneHit, stallAny;
    logic        rdLog [40];
    logic        wrLog [40];
    logic        stallLog [40];
    logic [15:0] addrLog [40];
    logic [15:0] wdLog [40];

    task automatic pokeLine(input logic [15:0] a, input logic [15:0] v);
        for (int k = 0; k < 4; k++) begin
            pokeEn = 1'b1; pokeAddr = a + 16'(2 * k); pokeData = v + 16'(k);
            @(posedge clk); #1;
        end
        pokeEn = 1'b0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [4:0] tag,
                           input logic dirty, input logic [15:0] base);
        preEn = 1'b1; preIdx = idx; preTag = tag; preDirty = dirty; preBase = base;
        @(posedge clk); #1;
        preEn = 1'b0;
    endtask

    // Entered and left just after a rising edge; cycle 0 is the request cycle.
    task automatic runReq(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d);
        doneCyc = -1; doneData = '0; doneHit = 1'b0; stallAny = 1'b0;
        for (int c = 0; c < 40; c++) begin
            rdLog[c] = 1'b0; wrLog[c] = 1'b0; stallLog[c] = 1'b0;
            addrLog[c] = '0; wdLog[c] = '0;
        end
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rdLog[c] = m_rd; wrLog[c] = m_wr; stallLog[c] = Stall;
            addrLog[c] = m_addr; wdLog[c] = m_data_in;
            if (Stall) stallAny = 1'b1;
            if (Done) begin doneCyc = c; doneData = DataOut; doneHit = CacheHit; end
            @(posedge clk); #1;
            if (doneCyc >= 0) break;
        end
        Rd = 1'b0; Wr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; tbInit = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0;
        @(posedge clk); #1;
        tbInit = 1'b0;
        Rd = 1'b1; Addr = 16'h0040;
        @(negedge clk);
        checks++;
        if (allOut !== '0) begin errors++; $display("FAIL reset_outputs_held got %h want 0", allOut); end
        @(posedge clk); #1;
        rst = 1'b0; Rd = 1'b0;
        @(negedge clk);
        checks++;
        if (allOut !== '0) begin errors++; $display("FAIL reset_idle_outputs got %h want 0", allOut); end
        @(posedge clk); #1;
    endtask

    task automatic test_read_hit();
        preload(8'h47, 5'h02, 1'b0, 16'h5A5A);
        runReq(1'b1, 1'b0, 16'h1238, 16'h0000);
        checks++;
        if (doneCyc !== 0) begin errors++; $display("FAIL hit_latency got %0d want 0", doneCyc); end
        checks++;
        if (doneHit !== 1'b1) begin errors++; $display("FAIL hit_cachehit got %b want 1", doneHit); end
        checks++;
        if (doneData !== 16'h5A5A) begin errors++; $display("FAIL hit_data got %h want 5a5a", doneData); end
        checks++;
        if (stallAny !== 1'b0) begin errors++; $display("FAIL hit_stall got %b want 0", stallAny); end
    endtask

    task automatic test_clean_miss();
        pokeLine(16'h0040, 16'h00A0);
        runReq(1'b1, 1'b0, 16'h0040, 16'h0000);
        checks++;
        if (doneCyc !== 7) begin errors++; $display("FAIL clean_done_cycle got %0d want 7", doneCyc); end
        checks++;
        if (doneData !== 16'h00A0) begin errors++; $display("FAIL clean_data got %h want 00a0", doneData); end
        checks++;
        if (doneHit !== 1'b0) begin errors++; $display("FAIL clean_cachehit got %b want 0", doneHit); end
        for (int c = 0; c < 6; c++) begin
            logic expRd;
            expRd = (c >= 1 && c <= 4);
            checks++;
            if (rdLog[c] !== expRd) begin errors++; $display("FAIL clean_m_rd cycle %0d got %b want %b", c, rdLog[c], expRd); end
            if (expRd) begin
                checks++;
                if (addrLog[c] !== 16'h0040 + 16'(2 * (c - 1))) begin
                    errors++; $display("FAIL clean_m_addr cycle %0d got %h want %h", c, addrLog[c], 16'h0040 + 16'(2 * (c - 1)));
                end
            end
        end
        checks++;
        if (stallLog[0] !== 1'b1 || stallLog[6] !== 1'b1 || stallLog[7] !== 1'b0) begin
            errors++; $display("FAIL clean_stall_window got %b%b%b want 110", stallLog[0], stallLog[6], stallLog[7]);
        end
    endtask

    task automatic test_dirty_miss();
        preload(8'h08, 5'h03, 1'b1, 16'h00D0);
        pokeLine(16'h0840, 16'h1110);
        runReq(1'b1, 1'b0, 16'h0840, 16'h0000);
        checks++;
        if (doneCyc !== 11) begin errors++; $display("FAIL dirty_done_cycle got %0d want 11", doneCyc); end
        checks++;
        if (doneData !== 16'h1110) begin errors++; $display("FAIL dirty_data got %h want 1110", doneData); end
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (wrLog[c] !== 1'b1 || addrLog[c] !== 16'h1840 + 16'(2 * (c - 1))) begin
                errors++; $display("FAIL dirty_wb cycle %0d got wr=%b addr=%h want wr=1 addr=%h", c, wrLog[c], addrLog[c], 16'h1840 + 16'(2 * (c - 1)));
            end
        end
        checks++;
        if (wdLog[1] !== 16'h00D0 || wdLog[4] !== 16'h00D3) begin
            errors++; $display("FAIL dirty_wb_data got %h/%h want 00d0/00d3", wdLog[1], wdLog[4]);
        end
        checks++;
        if (rdLog[4] !== 1'b0 || rdLog[5] !== 1'b1 || addrLog[5] !== 16'h0840) begin
            errors++; $display("FAIL dirty_rd_start got rd4=%b rd5=%b addr5=%h want 0 1 0840", rdLog[4], rdLog[5], addrLog[5]);
        end
    endtask

    task automatic test_write_miss();
        pokeLine(16'h0100, 16'h0B00);
        runReq(1'b0, 1'b1, 16'h0100, 16'hBEEF);
        checks++;
        if (doneCyc !== 7) begin errors++; $display("FAIL wmiss_done_cycle got %0d want 7", doneCyc); end
        checks++;
        if (dirtyA[8'h20] !== 1'b1) begin errors++; $display("FAIL wmiss_dirty got %b want 1", dirtyA[8'h20]); end
        runReq(1'b1, 1'b0, 16'h0100, 16'h0000);
        checks++;
        if (doneCyc !== 0 || doneHit !== 1'b1 || doneData !== 16'hBEEF) begin
            errors++; $display("FAIL wmiss_readback got cyc=%0d hit=%b data=%h want 0 1 beef", doneCyc, doneHit, doneData);
        end
        runReq(1'b1, 1'b0, 16'h0102, 16'h0000);
        checks++;
        if (doneCyc !== 0 || doneData !== 16'h0B01) begin
            errors++; $display("FAIL wmiss_word1 got cyc=%0d data=%h want 0 0b01", doneCyc, doneData);
        end
    endtask

    task automatic test_err();
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h0101;
        @(negedge clk);
        checks++;
        if (Err !== 1'b1) begin errors++; $display("FAIL err_misaligned got %b want 1", Err); end
        checks++;
        if ({m_rd, m_wr, c_enable, Done, Stall} !== 5'b0) begin
            errors++; $display("FAIL err_no_access got %b want 00000", {m_rd, m_wr, c_enable, Done, Stall});
        end
        @(posedge clk); #1;
        Rd = 1'b0;
        @(negedge clk);
        checks++;
        if (allOut !== '0) begin errors++; $display("FAIL err_stays_idle got %h want 0", allOut); end
        @(posedge clk); #1;
        Rd = 1'b1; Wr = 1'b1; Addr = 16'h0040;
        @(negedge clk);
        checks++;
        if (Err !== 1'b1 || c_enable !== 1'b0) begin
            errors++; $display("FAIL err_rdwr got err=%b en=%b want 1 0", Err, c_enable);
        end
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0;
    endtask

    task automatic test_reset_mid_miss();
        pokeLine(16'h2000, 16'h2200);
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h2000;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (m_rd !== 1'b1 || m_addr !== 16'h2000) begin
            errors++; $display("FAIL rstmid_rd0 got rd=%b addr=%h want 1 2000", m_rd, m_addr);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; Rd = 1'b0;
        @(negedge clk);
        checks++;
        if (allOut !== '0) begin errors++; $display("FAIL rstmid_during got %h want 0", allOut); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (allOut !== '0) begin errors++; $display("FAIL rstmid_after got %h want 0", allOut); end
        checks++;
        if (validA[8'h00] !== 1'b0) begin errors++; $display("FAIL rstmid_line_valid got %b want 0", validA[8'h00]); end
        @(posedge clk); #1;
        runReq(1'b1, 1'b0, 16'h2000, 16'h0000);
        checks++;
        if (doneCyc !== 7 || doneHit !== 1'b0 || doneData !== 16'h2200) begin
            errors++; $display("FAIL rstmid_rerequest got cyc=%0d hit=%b data=%h want 7 0 2200", doneCyc, doneHit, doneData);
        end
    endtask

    task automatic test_back_to_back();
        // A miss followed at once by a hit to the line it just filled.
        pokeLine(16'h3008, 16'h3300);
        runReq(1'b1, 1'b0, 16'h300A, 16'h0000);
        checks++;
        if (doneCyc !== 7 || doneData !== 16'h3301) begin
            errors++; $display("FAIL b2b_miss got cyc=%0d data=%h want 7 3301", doneCyc, doneData);
        end
        runReq(1'b1, 1'b0, 16'h300E, 16'h0000);
        checks++;
        if (doneCyc !== 0 || doneHit !== 1'b1 || doneData !== 16'h3303) begin
            errors++; $display("FAIL b2b_hit got cyc=%0d hit=%b data=%h want 0 1 3303", doneCyc, doneHit, doneData);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_dirty_miss();
        test_write_miss();
        test_err();
        test_reset_mid_miss();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
